// File: rtl/eth_mdio_pkg.sv
// Shared MDIO frame fields, register addresses and scheduler enums.
package eth_mdio_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] TA       = 2'b10;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;
    localparam int         BMSR_LINK = 2;

    // Who owns the current engine transaction.
    typedef enum logic [1:0] {INIT, HOST, POLL} grant_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    // Raw clause-22 frame: {ST, OP, PHYAD, REGAD, TA, DATA}.
    function automatic logic [31:0] mdio_frame(input logic [1:0]  op,
                                               input logic [4:0]  phy,
                                               input logic [4:0]  regad,
                                               input logic [15:0] data);
        return {ST, op, phy, regad, TA, data};
    endfunction

endpackage

// File: rtl/eth_mdio_sched.sv
// Arbitrates the single eth_mdio engine between the host path, a one-shot
// BMCR init write and a periodic BMSR poll that exports link state.
module eth_mdio_sched
    import eth_mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [23:0] POLL_PERIOD   = 24'd5_000_000,
    parameter logic [15:0] INIT_BMCR     = 16'h3100,
    parameter logic [4:0]  START_TIMEOUT = 5'd16
) (
    input  logic        clk50,
    input  logic        rstn,
    input  logic        host_req,
    input  logic [31:0] host_txdata,
    output logic        host_ack,
    output logic        host_err,
    output logic [15:0] host_rdata,
    output logic        init_done,
    output logic        link_up,
    output logic [15:0] link_status,
    output logic        mdio_read,
    output logic        mdio_write,
    output logic [31:0] mdio_txdata,
    input  logic [15:0] mdio_rxdata,
    input  logic        mdio_busy
);

    localparam logic [31:0] INIT_FRAME = mdio_frame(OP_WRITE, PHY_ADDR, REG_BMCR, INIT_BMCR);
    localparam logic [31:0] POLL_FRAME = mdio_frame(OP_READ, PHY_ADDR, REG_BMSR, 16'h0);

    state_t      state_q;
    grant_t      grant_q, last_grant_q;
    logic [23:0] timer_q, timer_d;
    logic        timer_wrap;
    logic        poll_pend_q;
    logic [4:0]  to_cnt_q;
    logic        to_hit;
    logic        fin, fin_abort;
    logic        gnt_vld;
    grant_t      gnt_sel;
    logic [31:0] gnt_frame;

    logic        host_ack_q, host_err_q, init_done_q, link_up_q;
    logic        mdio_read_q, mdio_write_q;
    logic [15:0] host_rdata_q, link_status_q;
    logic [31:0] txdata_q;

    assign host_ack    = host_ack_q;
    assign host_err    = host_err_q;
    assign host_rdata  = host_rdata_q;
    assign init_done   = init_done_q;
    assign link_up     = link_up_q;
    assign link_status = link_status_q;
    assign mdio_read   = mdio_read_q;
    assign mdio_write  = mdio_write_q;
    assign mdio_txdata = txdata_q;

    // Free-running poll timer; the wrap cycle raises a poll request.
    always_comb begin
        timer_wrap = (timer_q == POLL_PERIOD - 24'd1);
        timer_d    = timer_wrap ? 24'd0 : timer_q + 24'd1;
    end

    // Poll timer register.
    always_ff @(posedge clk50 or negedge rstn) begin
        if (!rstn) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    // Grant priority: init first, then host unless it just had the engine
    // while a poll is waiting, then the poll.
    always_comb begin
        gnt_vld   = 1'b1;
        gnt_sel   = INIT;
        gnt_frame = INIT_FRAME;
        if (!init_done_q) begin
            gnt_sel   = INIT;
            gnt_frame = INIT_FRAME;
        end else if (host_req && !(poll_pend_q && last_grant_q == HOST)) begin
            gnt_sel   = HOST;
            gnt_frame = host_txdata;
        end else if (poll_pend_q) begin
            gnt_sel   = POLL;
            gnt_frame = POLL_FRAME;
        end else begin
            gnt_vld   = 1'b0;
        end
    end

    // Transaction end: busy fell, or the engine never started in time.
    always_comb begin
        to_hit    = (to_cnt_q == START_TIMEOUT - 5'd1);
        fin       = ((state_q == S_WAIT_HI) && !mdio_busy && to_hit) ||
                    ((state_q == S_WAIT_LO) && !mdio_busy);
        fin_abort = (state_q == S_WAIT_HI);
    end

    // Scheduler FSM; completion side effects land on the edge entering DONE
    // so host_ack trails the busy fall by one cycle.
    always_ff @(posedge clk50 or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            grant_q       <= INIT;
            last_grant_q  <= POLL;
            poll_pend_q   <= 1'b0;
            to_cnt_q      <= '0;
            host_ack_q    <= 1'b0;
            host_err_q    <= 1'b0;
            host_rdata_q  <= '0;
            init_done_q   <= 1'b0;
            link_up_q     <= 1'b0;
            link_status_q <= '0;
            mdio_read_q   <= 1'b0;
            mdio_write_q  <= 1'b0;
            txdata_q      <= '0;
        end else begin
            mdio_write_q <= 1'b0;
            mdio_read_q  <= 1'b0;
            host_ack_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        grant_q      <= gnt_sel;
                        txdata_q     <= gnt_frame;
                        mdio_write_q <= 1'b1;
                        mdio_read_q  <= (gnt_frame[29:28] == OP_READ);
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (mdio_busy)   state_q  <= S_WAIT_LO;
                    else if (to_hit) state_q  <= S_DONE;
                    else             to_cnt_q <= to_cnt_q + 5'd1;
                end
                S_WAIT_LO: begin
                    if (!mdio_busy) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (fin) begin
                last_grant_q <= grant_q;
                case (grant_q)
                    HOST: begin
                        host_ack_q <= 1'b1;
                        host_err_q <= fin_abort;
                        if (!fin_abort && txdata_q[29:28] == OP_READ)
                            host_rdata_q <= mdio_rxdata;
                    end
                    POLL: begin
                        if (!fin_abort) begin
                            link_status_q <= mdio_rxdata;
                            link_up_q     <= mdio_rxdata[BMSR_LINK];
                        end
                        poll_pend_q <= 1'b0;
                    end
                    default: init_done_q <= 1'b1;
                endcase
            end

            // A wrap on the same edge as a poll completion keeps the request.
            if (timer_wrap) poll_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_mdio_sched.sv
// Directed bench for eth_mdio_sched with a behavioural eth_mdio engine model.
module tb_eth_mdio_sched;

    localparam logic [31:0] F_INIT = 32'h5082_3100;
    localparam logic [31:0] F_POLL = 32'h6086_0000;
    localparam logic [31:0] F_HRD  = 32'h6082_0000;
    localparam logic [31:0] F_HWR  = 32'h5086_ABCD;

    logic        clk50 = 1'b0;
    logic        rstn  = 1'b0;
    logic        host_req = 1'b0;
    logic [31:0] host_txdata = '0;
    logic        host_ack, host_err, init_done, link_up, mdio_read, mdio_write;
    logic [15:0] host_rdata, link_status;
    logic [31:0] mdio_txdata;
    logic [15:0] mdio_rxdata = '0;
    logic        mdio_busy;

    int total = 0;
    int bad   = 0;

    // engine model knobs
    logic        mock_nobusy = 1'b0;
    logic [15:0] mock_rx = '0;
    int          busy_len = 40;
    int          mcnt;
    int          ack_cnt = 0;
    int          hrd_cnt = 0;

    eth_mdio_sched #(.POLL_PERIOD(24'd100)) dut (
        .clk50       (clk50),
        .rstn        (rstn),
        .host_req    (host_req),
        .host_txdata (host_txdata),
        .host_ack    (host_ack),
        .host_err    (host_err),
        .host_rdata  (host_rdata),
        .init_done   (init_done),
        .link_up     (link_up),
        .link_status (link_status),
        .mdio_read   (mdio_read),
        .mdio_write  (mdio_write),
        .mdio_txdata (mdio_txdata),
        .mdio_rxdata (mdio_rxdata),
        .mdio_busy   (mdio_busy)
    );

    always #5 clk50 = ~clk50;

    // engine: busy rises 2 cycles after the strobe and lasts busy_len cycles
    always @(posedge clk50 or negedge rstn) begin
        if (!rstn) begin
            mdio_busy <= 1'b0;
            mcnt      <= 0;
        end else if (mdio_write && !mock_nobusy) begin
            mcnt        <= 1;
            mdio_rxdata <= mock_rx;
        end else if (mcnt != 0) begin
            mdio_busy <= (mcnt <= busy_len);
            mcnt      <= (mcnt > busy_len) ? 0 : mcnt + 1;
        end
    end

    always @(negedge clk50) begin
        if (host_ack) ack_cnt++;
        if (mdio_write && mdio_txdata == F_HRD) hrd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag, input int maxc,
                               output logic [31:0] tx, output logic rd);
        logic seen = 1'b0;
        tx = '0;
        rd = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk50);
            if (mdio_write) begin
                seen = 1'b1;
                tx   = mdio_txdata;
                rd   = mdio_read;
            end
        end
        chk(tag, {31'b0, seen}, 32'd1);
    endtask

    // returns at the first negedge with busy low after it was high
    task automatic wait_fall(input string tag);
        logic hi = 1'b0;
        logic lo = 1'b0;
        for (int i = 0; i < 200 && !hi; i++) begin
            @(negedge clk50);
            hi = mdio_busy;
        end
        for (int i = 0; i < 300 && hi && !lo; i++) begin
            @(negedge clk50);
            lo = !mdio_busy;
        end
        chk(tag, {31'b0, lo}, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bits"}, {26'b0, init_done, link_up, host_ack, host_err, mdio_write, mdio_read}, 32'd0);
        chk({tag, "_regs"}, {link_status, host_rdata}, 32'd0);
        chk({tag, "_tx"}, mdio_txdata, 32'd0);
    endtask

    initial begin
        logic [31:0] tx;
        logic        rd;
        logic [31:0] exp_seq [4];
        int          k;
        logic        got, err;
        int          acks;

        // reset state
        #1;
        chk_zero("rst");
        repeat (3) @(negedge clk50);
        rstn = 1'b1;

        // 1: init write
        wait_strobe("init_strobe", 20, tx, rd);
        chk("init_tx", tx, F_INIT);
        chk("init_rd", {31'b0, rd}, 32'd0);
        wait_fall("init_fall");
        chk("init_early", {31'b0, init_done}, 32'd0);
        @(negedge clk50);
        chk("init_done", {31'b0, init_done}, 32'd1);

        // 2: two polls, link up then down
        mock_rx = 16'h786D;
        wait_strobe("poll1_strobe", 200, tx, rd);
        chk("poll1_tx", tx, F_POLL);
        chk("poll1_rd", {31'b0, rd}, 32'd1);
        wait_fall("poll1_fall");
        @(negedge clk50);
        chk("poll1_stat", {16'b0, link_status}, 32'h786D);
        chk("poll1_link", {31'b0, link_up}, 32'd1);
        mock_rx = 16'h7869;
        wait_strobe("poll2_strobe", 200, tx, rd);
        wait_fall("poll2_fall");
        @(negedge clk50);
        chk("poll2_stat", {16'b0, link_status}, 32'h7869);
        chk("poll2_link", {31'b0, link_up}, 32'd0);

        // 3: host read
        mock_rx     = 16'h1234;
        host_txdata = F_HRD;
        host_req    = 1'b1;
        wait_strobe("hrd_strobe", 50, tx, rd);
        chk("hrd_tx", tx, F_HRD);
        chk("hrd_rd", {31'b0, rd}, 32'd1);
        wait_fall("hrd_fall");
        @(negedge clk50);
        chk("hrd_ack", {31'b0, host_ack}, 32'd1);
        chk("hrd_err", {31'b0, host_err}, 32'd0);
        chk("hrd_data", {16'b0, host_rdata}, 32'h1234);
        host_req = 1'b0;
        mock_rx  = 16'h786D;
        repeat (10) @(negedge clk50);
        chk("hrd_once", hrd_cnt, 32'd1);
        chk("hrd_acks", ack_cnt, 32'd1);

        // 4: contention alternates once a poll is pending
        wait_strobe("pre4_strobe", 300, tx, rd);
        chk("pre4_tx", tx, F_POLL);
        wait_fall("pre4_fall");
        busy_len    = 120;
        host_txdata = F_HWR;
        host_req    = 1'b1;
        exp_seq[0] = F_HWR; exp_seq[1] = F_POLL; exp_seq[2] = F_HWR; exp_seq[3] = F_POLL;
        for (int i = 0; i < 4; i++) begin
            wait_strobe($sformatf("alt%0d_strobe", i), 400, tx, rd);
            chk($sformatf("alt%0d_tx", i), tx, exp_seq[i]);
            chk($sformatf("alt%0d_rd", i), {31'b0, rd}, {31'b0, exp_seq[i] == F_POLL});
        end
        host_req = 1'b0;
        wait_fall("alt_fall");
        busy_len = 40;
        @(negedge clk50);
        chk("alt_stat", {16'b0, link_status}, 32'h786D);

        // 5: engine never starts
        mock_nobusy = 1'b1;
        host_txdata = F_HRD;
        host_req    = 1'b1;
        wait_strobe("to_strobe", 50, tx, rd);
        chk("to_tx", tx, F_HRD);
        k = 0; got = 1'b0; err = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk50);
            if (host_ack) begin
                got = 1'b1;
                k   = i;
                err = host_err;
            end
        end
        host_req = 1'b0;
        chk("to_lat", k, 32'd17);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_rdata", {16'b0, host_rdata}, 32'h1234);
        wait_strobe("topoll_strobe", 300, tx, rd);
        chk("topoll_tx", tx, F_POLL);
        repeat (20) @(negedge clk50);
        chk("topoll_stat", {16'b0, link_status}, 32'h786D);
        chk("topoll_link", {31'b0, link_up}, 32'd1);

        // 6: reset during WAIT_LO
        mock_nobusy = 1'b0;
        mock_rx     = 16'hBEEF;
        host_txdata = F_HRD;
        host_req    = 1'b1;
        wait_strobe("r6_strobe", 50, tx, rd);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk50);
            got = mdio_busy;
        end
        chk("r6_busy", {31'b0, got}, 32'd1);
        repeat (5) @(negedge clk50);
        acks = ack_cnt;
        rstn = 1'b0;
        #1;
        chk_zero("r6");
        host_req = 1'b0;
        repeat (3) @(negedge clk50);
        rstn = 1'b1;
        wait_strobe("r6_init_strobe", 20, tx, rd);
        chk("r6_init_tx", tx, F_INIT);
        chk("r6_noack", ack_cnt, acks);
        chk("r6_rdata", {16'b0, host_rdata}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
